// File: rtl/inv_mix_columns_seq.sv
// Iterative AES InvMixColumns engine: transforms COLS_PER_CYCLE columns of a 128-bit state per clock.
// Define INV_MIX_COLUMNS_FWD_EN to add a mode port (1 = forward MixColumns, 0 = inverse).
module inv_mix_columns_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef INV_MIX_COLUMNS_FWD_EN
    input  logic         mode,
`endif
    output logic [127:0] state_out
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int unsigned NumGroups = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LastCol   = 2'(NumGroups - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    // Coefficients built from xtime chains: 09=8^1, 0B=8^2^1, 0D=8^4^1, 0E=8^4^2.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8 * i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        for (int r_i = 0; r_i < 4; r_i++) begin
            r[31 - 8 * r_i -: 8] = me[2'(r_i)] ^ mb[2'(r_i + 1)] ^ md[2'(r_i + 2)]
                                   ^ m9[2'(r_i + 3)];
        end
        return r;
    endfunction

`ifdef INV_MIX_COLUMNS_FWD_EN
    function automatic logic [31:0] fwd_col(input logic [31:0] c);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31 - 8 * i -: 8];
            x2[i] = xtime(a[i]);
        end
        for (int r_i = 0; r_i < 4; r_i++) begin
            r[31 - 8 * r_i -: 8] = x2[2'(r_i)] ^ x2[2'(r_i + 1)] ^ a[2'(r_i + 1)]
                                   ^ a[2'(r_i + 2)] ^ a[2'(r_i + 3)];
        end
        return r;
    endfunction

    logic mode_q, mode_d;
`endif

    function automatic int unsigned col_top(input logic [1:0] col, input int unsigned k);
        return 127 - 32 * (COLS_PER_CYCLE * 32'(col) + k);
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        work_d  = work_q;
`ifdef INV_MIX_COLUMNS_FWD_EN
        mode_d  = mode_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StBusy;
                    col_d   = '0;
                    work_d  = state_in;
`ifdef INV_MIX_COLUMNS_FWD_EN
                    mode_d  = mode;
`endif
                end
            end
            StBusy: begin
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef INV_MIX_COLUMNS_FWD_EN
                    work_d[col_top(col_q, k) -: 32] = mode_q ?
                        fwd_col(work_q[col_top(col_q, k) -: 32]) :
                        inv_col(work_q[col_top(col_q, k) -: 32]);
`else
                    work_d[col_top(col_q, k) -: 32] = inv_col(work_q[col_top(col_q, k) -: 32]);
`endif
                end
                if (col_q == LastCol) begin
                    state_d = StDone;
                    col_d   = '0;
                end else begin
                    col_d = col_q + 2'd1;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            col_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            work_q  <= work_d;
        end
    end

`ifdef INV_MIX_COLUMNS_FWD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mode_q <= 1'b0;
        else        mode_q <= mode_d;
    end
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Scoreboard bench for inv_mix_columns_seq: one instance each for COLS_PER_CYCLE = 1, 2, 4.
`timescale 1ns/1ps
module tb_inv_mix_columns_seq;

    localparam logic [127:0] VIn  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] VOut = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    localparam logic [127:0] VFix = 128'hc6c6c6c6_01010101_c6c6c6c6_01010101;

    logic        clk = 1'b0;
    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned cyc    = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic fail(input string name);
        total++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Polynomial multiply then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic fwd);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] r;
        r = '0;
        if (fwd) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        else     coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[2'(j - row)], s[127 - 32 * c - 8 * j -: 8]);
                r[127 - 32 * c - 8 * row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int unsigned C = 1 << g;
        localparam int unsigned N = 4 / C;
        localparam int unsigned K = (N >= 3) ? 2 : N - 1;

        logic         rst_n, in_valid, in_ready, out_valid, out_ready, mode;
        logic [127:0] state_in, state_out, last_out, bp_exp;
        logic [127:0] exp_q [$];
        int unsigned  acc_q [$];
        logic         ov_prev;
        bit           b2b;
        int           last_hs;
        bit           done;

        inv_mix_columns_seq #(.COLS_PER_CYCLE(C)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .state_in  (state_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
`ifdef INV_MIX_COLUMNS_FWD_EN
            .mode      (mode),
`endif
            .state_out (state_out)
        );

        function automatic string nm(input string s);
            return $sformatf("c%0d_%s", C, s);
        endfunction

        // Monitor: expected result is pushed at acceptance, popped at the output handshake.
        initial forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                acc_q.delete();
                ov_prev = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    exp_q.push_back(mix(state_in, mode));
                    acc_q.push_back(cyc);
                end
                if (out_valid && !ov_prev) begin
                    if (acc_q.size() == 0) fail(nm("spurious_out_valid"));
                    else check(nm("latency"), 128'(cyc - acc_q.pop_front()), 128'(N + 1));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) fail(nm("unexpected_output"));
                    else check(nm("result"), state_out, exp_q.pop_front());
                    last_out = state_out;
                    if (b2b && last_hs >= 0)
                        check(nm("spacing"), 128'(cyc - 32'(last_hs)), 128'(N + 2));
                    last_hs = b2b ? int'(cyc) : -1;
                end
                ov_prev = out_valid;
            end
        end

        // Called at posedge+1; returns at posedge+1 just after the accepting edge.
        task automatic send(input logic [127:0] d, input logic m, input bit keep);
            bit ok;
            ok       = 1'b0;
            in_valid = 1'b1;
            state_in = d;
            mode     = m;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                ok = in_ready;
            end
            if (!ok) fail(nm("send_timeout"));
            @(posedge clk);
            #1;
            if (!keep) in_valid = 1'b0;
        endtask

        task automatic drain();
            int i;
            i = 0;
            while (i < 100 && !(exp_q.size() == 0 && !out_valid && in_ready)) begin
                @(posedge clk);
                #1;
                i++;
            end
            if (i >= 100) fail(nm("drain_timeout"));
        endtask

        initial begin
            logic [127:0] d;
            int           i;
            rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
            state_in = '0; b2b = 1'b0; last_hs = -1; done = 1'b0; ov_prev = 1'b0;
            last_out = '0;
            repeat (3) @(negedge clk);
            check(nm("rst_out_valid"), 128'(out_valid), 128'(0));
            check(nm("rst_in_ready"), 128'(in_ready), 128'(1));
            check(nm("rst_state_out"), state_out, 128'(0));
            rst_n = 1'b1;
            @(posedge clk);
            #1;

            send(VIn, 1'b0, 1'b0);
            drain();
            check(nm("known_vector"), last_out, VOut);
            send(VFix, 1'b0, 1'b0);
            drain();
            check(nm("fixed_point"), last_out, VFix);

            // Backpressure: result must hold while new inputs are offered.
            out_ready = 1'b0;
            d = rand128();
            bp_exp = mix(d, 1'b0);
            send(d, 1'b0, 1'b0);
            i = 0;
            while (i < 20 && !out_valid) begin
                @(posedge clk);
                #1;
                i++;
            end
            if (!out_valid) fail(nm("bp_wait_valid"));
            repeat (10) begin
                in_valid = 1'b1;
                state_in = rand128();
                @(negedge clk);
                check(nm("bp_in_ready"), 128'(in_ready), 128'(0));
                check(nm("bp_out_valid"), 128'(out_valid), 128'(1));
                check(nm("bp_state_out"), state_out, bp_exp);
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            @(negedge clk);
            check(nm("bp_release_in_ready"), 128'(in_ready), 128'(1));
            check(nm("bp_release_out_valid"), 128'(out_valid), 128'(0));
            @(posedge clk);
            #1;

            // Reset in the middle of BUSY discards the in-flight state.
            send(rand128(), 1'b0, 1'b0);
            repeat (K) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check(nm("midrst_out_valid"), 128'(out_valid), 128'(0));
            check(nm("midrst_in_ready"), 128'(in_ready), 128'(1));
            check(nm("midrst_state_out"), state_out, 128'(0));
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            send(rand128(), 1'b0, 1'b0);
            drain();

            b2b = 1'b1;
            last_hs = -1;
            for (int n = 0; n < 8; n++) send(rand128(), 1'b0, n < 7);
            drain();
            b2b = 1'b0;

`ifdef INV_MIX_COLUMNS_FWD_EN
            send(VOut, 1'b1, 1'b0);
            drain();
            check(nm("fwd_vector"), last_out, VIn);
            send(last_out, 1'b0, 1'b0);
            drain();
            check(nm("fwd_roundtrip"), last_out, VOut);
            for (int n = 0; n < 4; n++) begin
                send(rand128(), 1'($urandom_range(0, 1)), 1'b0);
                drain();
            end
`endif
            done = 1'b1;
        end
    end

    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int i = 0; i < 20000 && !all_done; i++) begin
            @(posedge clk);
            all_done = u[0].done && u[1].done && u[2].done;
        end
        if (!all_done) fail("global_timeout");
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
